// File: rtl/pet_pkg.sv
// Shared definitions for the pet need engine: the mode encoding and the
// seven-segment decode used for the displayed need level.
package pet_pkg;

    typedef enum logic [1:0] {
        MODE_NORMAL   = 2'd0,
        MODE_TEST     = 2'd1,
        MODE_CRITICAL = 2'd2
    } mode_e;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_FULL  = 7'h77;

    // Active-high gfedcba pattern; 10 shows as 'A' so a full need fits one digit.
    function automatic logic [6:0] seg_decode(input logic [7:0] value);
        logic [6:0] seg;
        case (value)
            8'd0:    seg = 7'h3F;
            8'd1:    seg = 7'h06;
            8'd2:    seg = 7'h5B;
            8'd3:    seg = 7'h4F;
            8'd4:    seg = 7'h66;
            8'd5:    seg = 7'h6D;
            8'd6:    seg = 7'h7D;
            8'd7:    seg = 7'h07;
            8'd8:    seg = 7'h7F;
            8'd9:    seg = 7'h6F;
            8'd10:   seg = SEG_FULL;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/pet_need_channel.sv
// One need channel: saturating level, decay timer and care-button hold counter.
// Care events take precedence over decay on the same tick.
module pet_need_channel
    import pet_pkg::*;
#(
    parameter int unsigned LVL_W      = 4,
    parameter int unsigned MAX_LEVEL  = 10,
    parameter int unsigned INIT_LEVEL = 8,
    parameter int unsigned HOLD_TICKS = 6,
    parameter logic [7:0]  DECAY_PER  = 8'd8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             srst_i,
    input  logic             tick_i,
    input  mode_e            mode_i,
    input  logic             care_i,
    input  logic             win_i,
    output logic [LVL_W-1:0] level_o
);

    localparam int unsigned HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS + 1) : 1;

    logic [LVL_W-1:0]  level_q, level_d;
    logic [7:0]        timer_q, timer_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              care_evt_s;

    // Hold counter: only the arbitration winner accumulates; anyone else clears.
    always_comb begin
        hold_d     = hold_q;
        care_evt_s = 1'b0;
        if (!win_i) begin
            hold_d = '0;
        end else if (tick_i) begin
            if (hold_q == HOLD_W'(HOLD_TICKS - 1)) begin
                care_evt_s = 1'b1;
                hold_d     = '0;
            end else begin
                hold_d = hold_q + HOLD_W'(1);
            end
        end else begin
            hold_d = hold_q;
        end
    end

    // Level and decay timer update; TEST mode toggles between 1 and full.
    always_comb begin
        level_d = level_q;
        timer_d = timer_q;
        if (care_evt_s) begin
            if (mode_i == MODE_TEST) begin
                level_d = (level_q == LVL_W'(1)) ? LVL_W'(MAX_LEVEL) : LVL_W'(1);
            end else begin
                level_d = (level_q >= LVL_W'(MAX_LEVEL)) ? LVL_W'(MAX_LEVEL)
                                                         : level_q + LVL_W'(1);
                timer_d = 8'd0;
            end
        end else if (tick_i && (mode_i != MODE_TEST) && !care_i) begin
            if (timer_q == DECAY_PER - 8'd1) begin
                level_d = (level_q == LVL_W'(0)) ? LVL_W'(0) : level_q - LVL_W'(1);
                timer_d = 8'd0;
            end else begin
                timer_d = timer_q + 8'd1;
            end
        end else begin
            level_d = level_q;
            timer_d = timer_q;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= LVL_W'(INIT_LEVEL);
            timer_q <= 8'd0;
            hold_q  <= '0;
        end else if (srst_i) begin
            level_q <= LVL_W'(INIT_LEVEL);
            timer_q <= 8'd0;
            hold_q  <= '0;
        end else begin
            level_q <= level_d;
            timer_q <= timer_d;
            hold_q  <= hold_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/pet_need_engine.sv
// Virtual-pet need engine: game-tick prescaler, care-button arbitration,
// NUM_NEEDS decaying need channels, mode FSM and registered level display.
module pet_need_engine
    import pet_pkg::*;
#(
    parameter int unsigned NUM_NEEDS  = 4,
    parameter int unsigned LVL_W      = 4,
    parameter int unsigned MAX_LEVEL  = 10,
    parameter int unsigned INIT_LEVEL = 8,
    parameter int unsigned HAPPY_THR  = 5,
    parameter int unsigned TICK_DIV   = 7500000,
    parameter int unsigned HOLD_TICKS = 6,
    parameter logic [NUM_NEEDS*8-1:0] DECAY_PER = {8'd8, 8'd10, 8'd15, 8'd20},
    localparam int unsigned SEL_W = (NUM_NEEDS > 1) ? $clog2(NUM_NEEDS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_NEEDS-1:0]       btn_care,
    input  logic                       btn_test,
    input  logic                       btn_soft_reset,
    output logic [NUM_NEEDS*LVL_W-1:0] levels,
    output logic [SEL_W-1:0]           sel_idx,
    output logic                       sel_happy,
    output logic [6:0]                 seg_display,
    output logic [1:0]                 mode
);

    localparam int unsigned PRE_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic        INIT_HAPPY = (INIT_LEVEL >= HAPPY_THR) ? 1'b1 : 1'b0;

    logic [PRE_W-1:0]     presc_q, presc_d;
    logic                 tick_s;
    logic [NUM_NEEDS-1:0] care_prev_q;
    logic                 test_prev_q;
    logic                 test_rise_s;
    logic                 care_rise_s;
    logic [NUM_NEEDS-1:0] win_vec_s;
    logic [SEL_W-1:0]     win_idx_s;
    logic [LVL_W-1:0]     level_s [NUM_NEEDS];
    logic [LVL_W-1:0]     sel_level_s;
    logic                 any_zero_s;
    mode_e                mode_q, mode_d;
    logic [SEL_W-1:0]     sel_idx_q;
    logic [6:0]           seg_q;
    logic                 happy_q;

    assign tick_s  = (presc_q == PRE_W'(TICK_DIV - 1));
    assign presc_d = tick_s ? '0 : presc_q + PRE_W'(1);

    // Game-tick prescaler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else if (btn_soft_reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // Input history for edge detection; a game restart does not re-arm it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            care_prev_q <= '0;
            test_prev_q <= 1'b0;
        end else begin
            care_prev_q <= btn_care;
            test_prev_q <= btn_test;
        end
    end

    assign test_rise_s = btn_test & ~test_prev_q;
    assign care_rise_s = |(btn_care & ~care_prev_q);
    // Two's-complement trick isolates the lowest asserted button.
    assign win_vec_s   = btn_care & (~btn_care + NUM_NEEDS'(1));

    // Encode the one-hot winner into an index.
    always_comb begin
        win_idx_s = '0;
        for (int i = 0; i < int'(NUM_NEEDS); i++) begin
            win_idx_s = win_idx_s | (SEL_W'(i) & {SEL_W{win_vec_s[i]}});
        end
    end

    for (genvar g = 0; g < NUM_NEEDS; g++) begin : g_ch
        pet_need_channel #(
            .LVL_W      (LVL_W),
            .MAX_LEVEL  (MAX_LEVEL),
            .INIT_LEVEL (INIT_LEVEL),
            .HOLD_TICKS (HOLD_TICKS),
            .DECAY_PER  (DECAY_PER[g*8 +: 8])
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .srst_i  (btn_soft_reset),
            .tick_i  (tick_s),
            .mode_i  (mode_q),
            .care_i  (btn_care[g]),
            .win_i   (win_vec_s[g]),
            .level_o (level_s[g])
        );
        assign levels[g*LVL_W +: LVL_W] = level_s[g];
    end

    // Flag any starving need for the CRITICAL transitions.
    always_comb begin
        any_zero_s = 1'b0;
        for (int i = 0; i < int'(NUM_NEEDS); i++) begin
            any_zero_s = any_zero_s | (level_s[i] == LVL_W'(0));
        end
    end

    // Mode next-state logic.
    always_comb begin
        mode_d = mode_q;
        case (mode_q)
            MODE_NORMAL: begin
                if (test_rise_s) begin
                    mode_d = MODE_TEST;
                end else if (any_zero_s) begin
                    mode_d = MODE_CRITICAL;
                end else begin
                    mode_d = MODE_NORMAL;
                end
            end
            MODE_TEST: begin
                if (test_rise_s) begin
                    mode_d = MODE_NORMAL;
                end else begin
                    mode_d = MODE_TEST;
                end
            end
            MODE_CRITICAL: begin
                if (test_rise_s) begin
                    mode_d = MODE_TEST;
                end else if (!any_zero_s) begin
                    mode_d = MODE_NORMAL;
                end else begin
                    mode_d = MODE_CRITICAL;
                end
            end
            default: mode_d = MODE_NORMAL;
        endcase
    end

    // Mode state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_NORMAL;
        end else if (btn_soft_reset) begin
            mode_q <= MODE_NORMAL;
        end else begin
            mode_q <= mode_d;
        end
    end

    assign sel_level_s = level_s[sel_idx_q];

    // Display registers trail the level registers by one clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_idx_q <= '0;
            seg_q     <= SEG_BLANK;
            happy_q   <= INIT_HAPPY;
        end else if (btn_soft_reset) begin
            sel_idx_q <= '0;
            seg_q     <= SEG_BLANK;
            happy_q   <= INIT_HAPPY;
        end else begin
            sel_idx_q <= care_rise_s ? win_idx_s : sel_idx_q;
            seg_q     <= seg_decode(8'(sel_level_s));
            happy_q   <= (sel_level_s >= LVL_W'(HAPPY_THR));
        end
    end

    assign sel_idx     = sel_idx_q;
    assign seg_display = seg_q;
    assign sel_happy   = happy_q;
    assign mode        = mode_q;

endmodule
